// File: rtl/game_score_pkg.sv
// Shared definitions for the score display block.
//   conv_state_t / StIdle, StShift, StDone : converter FSM state encoding
//   SegTable  : a..g patterns for decimal digits 0..9 (bit 6 = a, bit 0 = g)
//   SegBlank  : all segments off, dp off
//   seg_decode: BCD nibble -> abcdefgh (dp always 0, non-decimal nibbles blank)
package game_score_pkg;

  typedef logic [1:0] conv_state_t;

  localparam conv_state_t StIdle  = 2'd0;
  localparam conv_state_t StShift = 2'd1;
  localparam conv_state_t StDone  = 2'd2;

  localparam logic [7:0] SegBlank = 8'h00;

  // Entry 0 is the rightmost element.
  localparam logic [9:0][6:0] SegTable = {
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return SegBlank;
    end
    return {SegTable[nibble], 1'b0};
  endfunction

endpackage

// File: rtl/game_score_if.sv
// Bundle between the game top level and the score display.
//   count      : live score (game side drives)
//   show_high  : 1 = display high score, 0 = display live score
//   abcdefgh   : segment drive, active-high, bit 7 = a .. bit 0 = dp
//   digit      : one-hot digit enable, bit 0 = least significant digit
//   high_score : maximum count seen since reset
//   busy       : decimal conversion in progress
// master = game side, slave = display block.
interface game_score_if #(
  parameter int unsigned w_count = 16,
  parameter int unsigned digits  = 5
) ();

  logic [w_count-1:0] count;
  logic               show_high;
  logic [7:0]         abcdefgh;
  logic [digits-1:0]  digit;
  logic [w_count-1:0] high_score;
  logic               busy;

  modport master (
    output count, show_high,
    input  abcdefgh, digit, high_score, busy
  );

  modport slave (
    input  count, show_high,
    output abcdefgh, digit, high_score, busy
  );

endinterface

// File: rtl/game_bin2bcd.sv
// Sequential double-dabble binary to BCD converter, one bit per cycle.
//   clk, rst : clock, asynchronous active-low reset
//   start    : sampled in idle; loads bin and begins a conversion
//   bin      : binary value to convert
//   busy     : high while shifting and in the final done cycle
//   done     : high for the single cycle in which bcd holds the result
//   bcd      : BCD accumulator, digits nibbles, nibble 0 least significant
module game_bin2bcd
  import game_score_pkg::*;
#(
  parameter int unsigned w_count = 16,
  parameter int unsigned digits  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [w_count-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*digits-1:0]   bcd
);

  localparam int unsigned CntW = (w_count > 1) ? $clog2(w_count) : 1;

  conv_state_t         state_q, state_d;
  logic [w_count-1:0]  bin_q, bin_d;
  logic [4*digits-1:0] bcd_q, bcd_d;
  logic [4*digits-1:0] adj;
  logic [CntW-1:0]     cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = bcd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = CntW'(w_count - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        // Pre-correct each nibble so the shift carries into the next decade.
        for (int i = 0; i < int'(digits); i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {adj[4*digits-2:0], bin_q, 1'b0};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;

endmodule

// File: rtl/game_score_display.sv
// Score display: tracks the high score, converts the selected score to
// decimal and scans it onto a multiplexed seven-segment display.
//   clk, rst : game clock, asynchronous active-low reset
//   bus      : game_score_if slave (count/show_high in; abcdefgh, digit,
//              high_score, busy out)
// Optional build macro GAME_SCORE_LEADING_ZERO_BLANK_EN: blank leading-zero
// digits (digit 0 is always shown). Undefined: all digits shown.
module game_score_display
  import game_score_pkg::*;
#(
  parameter int unsigned clk_mhz               = 50,
  parameter int unsigned w_count               = 16,
  parameter int unsigned digits                = 5,
  parameter int unsigned refresh_counter_width = 16
) (
  input  logic         clk,
  input  logic         rst,
  game_score_if.slave  bus
);

  localparam longint unsigned MaxCount = (64'd1 << w_count) - 64'd1;
  localparam longint unsigned DecRange = 64'd10 ** digits;

  if (clk_mhz == 0 || DecRange <= MaxCount) begin : g_bad_params
    $error("game_score_display: digits too small for w_count, or clk_mhz is zero");
  end

  logic [w_count-1:0]               high_score_q, high_score_d;
  logic [w_count-1:0]               last_src_q, last_src_d;
  logic [4*digits-1:0]              disp_bcd_q, disp_bcd_d;
  logic [refresh_counter_width-1:0] refresh_q, refresh_d;
  logic [digits-1:0]                digit_q, digit_d;
  logic [7:0]                       seg_q, seg_d;
  logic [w_count-1:0]               src;
  logic                             start;
  logic                             conv_busy;
  logic                             conv_done;
  logic [4*digits-1:0]              conv_bcd;
  logic [3:0]                       nibble;
  logic                             zero_above;

  assign src          = bus.show_high ? high_score_q : bus.count;
  // A source that changed while converting stays != last_src and restarts here.
  assign start        = !conv_busy && (src != last_src_q);
  assign last_src_d   = start ? src : last_src_q;
  assign high_score_d = (bus.count > high_score_q) ? bus.count : high_score_q;
  assign disp_bcd_d   = conv_done ? conv_bcd : disp_bcd_q;
  assign refresh_d    = refresh_q + 1'b1;
  assign digit_d      = (&refresh_q) ? {digit_q[digits-2:0], digit_q[digits-1]} : digit_q;

  game_bin2bcd #(
    .w_count (w_count),
    .digits  (digits)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (src),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Decode from next-state values so segments, digit and disp_bcd move together.
  always_comb begin
    nibble     = '0;
    zero_above = 1'b1;
    for (int i = 0; i < int'(digits); i++) begin
      if (digit_d[i]) begin
        nibble = disp_bcd_d[4*i +: 4];
      end
    end
    seg_d = seg_decode(nibble);
`ifdef GAME_SCORE_LEADING_ZERO_BLANK_EN
    for (int i = int'(digits) - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_bcd_d[4*i +: 4] == 4'd0);
      if (digit_d[i] && zero_above) begin
        seg_d = SegBlank;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_score_q <= '0;
      last_src_q   <= '0;
      disp_bcd_q   <= '0;
      refresh_q    <= '0;
      digit_q      <= digits'(1);
      seg_q        <= seg_decode(4'd0);
    end else begin
      high_score_q <= high_score_d;
      last_src_q   <= last_src_d;
      disp_bcd_q   <= disp_bcd_d;
      refresh_q    <= refresh_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.abcdefgh   = seg_q;
  assign bus.digit      = digit_q;
  assign bus.high_score = high_score_q;
  assign bus.busy       = conv_busy;

endmodule

// File: tb/tb_game_score_display.sv
// Bench for game_score_display: a score-level model (high score, conversion
// timer, displayed decimal value, scan position) checked every cycle, plus
// directed literal expectations. Scan period shortened to 2^4 cycles per digit.
module tb_game_score_display;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;
  localparam int unsigned R = 4;
`ifdef GAME_SCORE_LEADING_ZERO_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif
  localparam logic [7:0] LeadZero = BlankEn ? 8'h00 : 8'hFC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_score_if #(.w_count(W), .digits(D)) bus ();

  game_score_display #(
    .clk_mhz               (50),
    .w_count               (W),
    .digits                (D),
    .refresh_counter_width (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [7:0] seg_tbl [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p = 1;
    for (int k = 0; k < int'(n); k++) p = p * 10;
    return p;
  endfunction

  // Model: scores in plain integers; a conversion occupies W+2 edges from the
  // edge that accepts it, and only the latest accepted value becomes visible.
  int unsigned m_hs, m_last, m_disp, m_timer, m_edges;

  always @(posedge clk or negedge rst) begin
    int unsigned src;
    if (!rst) begin
      m_hs = 0; m_last = 0; m_disp = 0; m_timer = 0; m_edges = 0;
    end else begin
      src = bus.show_high ? m_hs : int'(bus.count);
      if (m_timer == 0) begin
        if (src != m_last) begin
          m_last  = src;
          m_timer = W + 1;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) m_disp = m_last;
      end
      if (int'(bus.count) > m_hs) m_hs = bus.count;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    int unsigned idx, p;
    logic [7:0]  exp_seg;
    logic [D-1:0] one;
    if (chk_en) begin
      one     = 1;
      idx     = (m_edges >> R) % D;
      p       = pow10(idx);
      exp_seg = seg_tbl[(m_disp / p) % 10];
      if (BlankEn && idx > 0 && m_disp < p) exp_seg = 8'h00;
      check("model_abcdefgh", bus.abcdefgh, exp_seg);
      check("model_digit", bus.digit, one << idx);
      check("model_high_score", bus.high_score, m_hs);
      check("model_busy", bus.busy, m_timer != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a digit to become active, then compare its segments.
  task automatic wait_digit(input int idx, input logic [7:0] exp, input string name);
    bit seen = 1'b0;
    logic [D-1:0] one = 1;
    for (int k = 0; k < int'(D * (1 << R)) + 4; k++) begin
      @(negedge clk);
      if (bus.digit == (one << idx)) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      check(name, bus.abcdefgh, exp);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL %s @%0t: digit %0d never active, got digit %0h", name, $time, idx,
               bus.digit);
    end
  endtask

  initial begin
    bus.count     = 16'd1234;
    bus.show_high = 1'b0;
    rst           = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("rst_abcdefgh", bus.abcdefgh, 8'hFC);
    check("rst_digit", bus.digit, 5'b00001);
    check("rst_high_score", bus.high_score, 0);
    check("rst_busy", bus.busy, 0);

    // 12345: 18-cycle conversion, then scan 5,4,3,2,1.
    bus.count = 16'd12345;
    rst       = 1'b1;
    tick(1);
    check("conv_busy_first", bus.busy, 1);
    check("conv_high_score", bus.high_score, 12345);
    tick(16);
    check("conv_busy_last", bus.busy, 1);
    tick(1);
    check("conv_idle", bus.busy, 0);
    wait_digit(0, 8'hB6, "scan_d0");
    wait_digit(1, 8'h66, "scan_d1");
    wait_digit(2, 8'hF2, "scan_d2");
    wait_digit(3, 8'hDA, "scan_d3");
    wait_digit(4, 8'h60, "scan_d4");

    // Maximum value, then high score hold and show_high.
    tick(1);
    bus.count = 16'hFFFF;
    tick(17);
    check("max_busy_last", bus.busy, 1);
    tick(1);
    check("max_idle", bus.busy, 0);
    check("max_high_score", bus.high_score, 65535);
    wait_digit(4, 8'hBE, "max_d4");
    wait_digit(0, 8'hB6, "max_d0");
    tick(1);
    bus.count = 16'd0;
    tick(1);
    check("hs_hold", bus.high_score, 65535);
    tick(17);
    check("zero_idle", bus.busy, 0);
    wait_digit(4, LeadZero, "zero_d4");
    wait_digit(0, 8'hFC, "zero_d0");
    tick(1);
    bus.show_high = 1'b1;
    tick(17);
    check("high_busy_last", bus.busy, 1);
    tick(1);
    check("high_idle", bus.busy, 0);
    wait_digit(4, 8'hBE, "high_d4");
    wait_digit(1, 8'hF2, "high_d1");

    // 7 then 42 mid-conversion: second conversion ends 36 edges after first change.
    tick(1);
    bus.show_high = 1'b0;
    bus.count     = 16'd7;
    tick(5);
    bus.count = 16'd42;
    tick(13);
    check("chg_gap_idle", bus.busy, 0);
    tick(1);
    check("chg_restart", bus.busy, 1);
    tick(16);
    check("chg_busy_35", bus.busy, 1);
    tick(1);
    check("chg_idle_36", bus.busy, 0);
    wait_digit(0, 8'hDA, "chg_d0");
    wait_digit(1, 8'h66, "chg_d1");

    // Leading zeros for 7.
    tick(1);
    bus.count = 16'd7;
    tick(18);
    check("seven_idle", bus.busy, 0);
    wait_digit(0, 8'hE0, "seven_d0");
    for (int i = 1; i < int'(D); i++) wait_digit(i, LeadZero, $sformatf("seven_d%0d", i));

    // Asynchronous reset during SHIFT.
    tick(1);
    bus.count = 16'd999;
    tick(5);
    #2 rst = 1'b0;
    #1;
    check("arst_abcdefgh", bus.abcdefgh, 8'hFC);
    check("arst_digit", bus.digit, 5'b00001);
    check("arst_high_score", bus.high_score, 0);
    check("arst_busy", bus.busy, 0);
    bus.count = 16'd0;
    tick(2);
    rst = 1'b1;
    tick(20);
    check("post_busy", bus.busy, 0);
    check("post_high_score", bus.high_score, 0);
    wait_digit(0, 8'hFC, "post_d0");
    wait_digit(2, LeadZero, "post_d2");

    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
